// File: rtl/sram_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_bus_arbiter_pkg
// Purpose  : Shared constants for the SRAM bus arbiter and its FIFO.
//            Requester IDs double as the FIFO payload so a response can be
//            routed back to the channel that issued it.
// Revision : 1.0 - initial release
// ============================================================================
package sram_bus_arbiter_pkg;

  // Requester IDs (1-bit payload stored in the outstanding-ID FIFO)
  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;

  // Reset program counter; fetch uses the same value for its first request
  localparam logic [31:0] RESET_PC = 32'h1c00_0000;

endpackage : sram_bus_arbiter_pkg
`default_nettype wire

// File: rtl/sram_id_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sram_id_fifo
// Purpose  : 1-bit wide, DEPTH-deep FIFO. It records which requester owns
//            each accepted-but-unanswered memory request, in issue order.
// Ports    : clk, rst     - clock, asynchronous active-high reset
//            push_i       - enqueue push_id_i (ignored when full)
//            push_id_i    - requester ID to enqueue
//            pop_i        - dequeue the head (ignored when empty)
//            full_o       - DEPTH entries held
//            empty_o      - no entries held
//            head_o       - ID at the head of the queue
// Revision : 1.0 - initial release
// ============================================================================
module sram_id_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic push_id_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output logic head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0] ids_q, ids_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic w_push;
  logic w_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = ids_q[rd_ptr_q];

  assign w_push = push_i & ~full_o;
  assign w_pop  = pop_i & ~empty_o;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    ids_d    = ids_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push) begin
      ids_d[wr_ptr_q] = push_id_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ids_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      ids_q    <= ids_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule : sram_id_fifo
`default_nettype wire

// File: rtl/sram_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_bus_arbiter
// Purpose  : Shares one SRAM-like memory port (req/addr_ok/data_ok) between
//            the instruction fetch channel and the MEM-stage data channel.
//            Fixed priority with grant locking while a request waits for
//            addr_ok; responses routed in order via an outstanding-ID FIFO.
// Ports    : clk, rst                       - clock, async active-high reset
//            inst_req/inst_addr             - instruction read request
//            inst_addr_ok/inst_data_ok/inst_rdata - instruction handshakes
//            data_req/data_wr/data_addr/data_wstrb/data_wdata - data request
//            data_addr_ok/data_data_ok/data_rdata - data handshakes
//            mem_req/mem_wr/mem_addr/mem_wstrb/mem_wdata - memory request
//            mem_addr_ok/mem_data_ok/mem_rdata - memory handshakes/read data
// Revision : 1.0 - initial release
// ============================================================================
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter bit DATA_FIRST      = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  // instruction channel
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data channel
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // memory port
  output logic        mem_req,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  // Lock holds the grant on a requester whose request is on the bus but not
  // yet accepted, so the memory never sees the payload switch mid-request.
  logic lock_vld_q, lock_vld_d;
  logic lock_id_q,  lock_id_d;

  logic w_gnt_id;
  logic w_gnt_req;
  logic w_can_issue;
  logic w_handshake;
  logic w_pop;

  logic w_fifo_full;
  logic w_fifo_empty;
  logic w_fifo_head;

  // --------------------------------------------------------------------------
  // Grant selection
  // --------------------------------------------------------------------------
  always_comb begin
    w_gnt_id = ID_INST;
    if (lock_vld_q) begin
      w_gnt_id = lock_id_q;
    end else if (inst_req && data_req) begin
      w_gnt_id = DATA_FIRST ? ID_DATA : ID_INST;
    end else if (data_req) begin
      w_gnt_id = ID_DATA;
    end
  end

  assign w_gnt_req   = (w_gnt_id == ID_DATA) ? data_req : inst_req;
  // A pop in the same cycle does not free a slot: full blocks issue outright.
  assign w_can_issue = ~w_fifo_full & ~rst;
  assign mem_req     = w_can_issue & w_gnt_req;
  assign w_handshake = mem_req & mem_addr_ok;

  // --------------------------------------------------------------------------
  // Zero-latency request pass-through; payload is zero when nothing is issued
  // and write fields are zero for instruction reads.
  // --------------------------------------------------------------------------
  always_comb begin
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wstrb = '0;
    mem_wdata = '0;
    if (mem_req) begin
      if (w_gnt_id == ID_DATA) begin
        mem_wr    = data_wr;
        mem_addr  = data_addr;
        mem_wstrb = data_wstrb;
        mem_wdata = data_wdata;
      end else begin
        mem_addr  = inst_addr;
      end
    end
  end

  assign inst_addr_ok = w_handshake & (w_gnt_id == ID_INST);
  assign data_addr_ok = w_handshake & (w_gnt_id == ID_DATA);

  // --------------------------------------------------------------------------
  // Lock register
  // --------------------------------------------------------------------------
  always_comb begin
    lock_vld_d = lock_vld_q;
    lock_id_d  = lock_id_q;
    if (mem_req && !mem_addr_ok) begin
      lock_vld_d = 1'b1;
      lock_id_d  = w_gnt_id;
    end else if (w_handshake) begin
      lock_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_vld_q <= 1'b0;
      lock_id_q  <= ID_INST;
    end else begin
      lock_vld_q <= lock_vld_d;
      lock_id_q  <= lock_id_d;
    end
  end

  // --------------------------------------------------------------------------
  // Response routing. A response with nothing outstanding (e.g. stale after
  // a reset) is dropped.
  // --------------------------------------------------------------------------
  assign w_pop = mem_data_ok & ~w_fifo_empty & ~rst;

  sram_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (w_handshake),
    .push_id_i (w_gnt_id),
    .pop_i     (w_pop),
    .full_o    (w_fifo_full),
    .empty_o   (w_fifo_empty),
    .head_o    (w_fifo_head)
  );

  assign inst_data_ok = w_pop & (w_fifo_head == ID_INST);
  assign data_data_ok = w_pop & (w_fifo_head == ID_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

endmodule : sram_bus_arbiter
`default_nettype wire

// File: tb/tb_sram_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_bus_arbiter
// Purpose  : Self-checking bench for sram_bus_arbiter. A transaction-level
//            model (queue of outstanding owners, current bus owner) predicts
//            every output each cycle; directed scenarios add spot checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_bus_arbiter;

  localparam int MAXO = 4;
  localparam bit DFIRST = 1'b1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0;
  logic        data_wr = 1'b0;
  logic [31:0] data_addr = '0;
  logic [3:0]  data_wstrb = '0;
  logic [31:0] data_wdata = '0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_addr_ok = 1'b0;
  logic        mem_data_ok = 1'b0;
  logic [31:0] mem_rdata = '0;

  sram_bus_arbiter #(
    .MAX_OUTSTANDING (MAXO),
    .DATA_FIRST      (DFIRST)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_addr    (data_addr),
    .data_wstrb   (data_wstrb),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_addr     (mem_addr),
    .mem_wstrb    (mem_wstrb),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  // Model state: owners of accepted-but-unanswered requests (oldest first),
  // and the requester currently presenting an unaccepted request on the bus.
  bit outq[$];
  bit own_v  = 1'b0;
  bit own_id = 1'b0;

  // Model predictions and DUT samples of the last cycle
  bit          e_iaok, e_daok;
  logic        s_mem_req, s_mem_wr, s_iaok, s_daok, s_idok, s_ddok;
  logic [31:0] s_mem_addr, s_mem_wdata, s_irdata;
  logic [3:0]  s_mem_wstrb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock cycle: inputs are already applied; check at the falling edge,
  // advance the model, then return 1 time unit after the rising edge.
  task automatic tick();
    bit          gid, greq, can, emreq, hs, rsp, rid;
    logic        ewr;
    logic [31:0] ea, ewd;
    logic [3:0]  ews;
    @(negedge clk);
    if (rst) begin
      outq.delete();
      own_v = 1'b0;
    end
    can = (outq.size() < MAXO);
    if (own_v)                      gid = own_id;
    else if (inst_req && data_req)  gid = DFIRST;
    else                            gid = data_req;
    greq  = gid ? data_req : inst_req;
    emreq = can && greq && !rst;
    ewr = 1'b0; ea = '0; ews = '0; ewd = '0;
    if (emreq) begin
      if (gid) begin
        ewr = data_wr; ea = data_addr; ews = data_wstrb; ewd = data_wdata;
      end else begin
        ea = inst_addr;
      end
    end
    hs  = emreq && mem_addr_ok;
    rsp = mem_data_ok && (outq.size() > 0) && !rst;
    rid = rsp ? outq[0] : 1'b0;
    e_iaok = hs && !gid;
    e_daok = hs && gid;

    s_mem_req = mem_req; s_mem_wr = mem_wr; s_mem_addr = mem_addr;
    s_mem_wstrb = mem_wstrb; s_mem_wdata = mem_wdata;
    s_iaok = inst_addr_ok; s_daok = data_addr_ok;
    s_idok = inst_data_ok; s_ddok = data_data_ok; s_irdata = inst_rdata;

    chk("mem_req",      mem_req,      emreq);
    chk("mem_wr",       mem_wr,       ewr);
    chk("mem_addr",     mem_addr,     ea);
    chk("mem_wstrb",    mem_wstrb,    ews);
    chk("mem_wdata",    mem_wdata,    ewd);
    chk("inst_addr_ok", inst_addr_ok, e_iaok);
    chk("data_addr_ok", data_addr_ok, e_daok);
    chk("inst_data_ok", inst_data_ok, rsp && !rid);
    chk("data_data_ok", data_data_ok, rsp && rid);
    chk("inst_rdata",   inst_rdata,   mem_rdata);
    chk("data_rdata",   data_rdata,   mem_rdata);

    if (rsp) void'(outq.pop_front());
    if (hs) begin
      outq.push_back(gid);
      own_v = 1'b0;
    end else if (emreq) begin
      own_v  = 1'b1;
      own_id = gid;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_req = 0; data_req = 0; data_wr = 0; data_wstrb = '0; data_wdata = '0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
  endtask

  initial begin
    #1;
    // ---------------- reset ----------------
    rst = 1; idle();
    tick();
    chk("rst_mem_req", s_mem_req, 1'b0);
    chk("rst_mem_addr", s_mem_addr, 32'h0);
    tick();
    rst = 0;
    tick();

    // ---------------- inst only ----------------
    inst_req = 1; inst_addr = 32'h1c00_0000; mem_addr_ok = 1;
    tick();
    chk("inst_issue_aok", s_iaok, 1'b1);
    chk("inst_issue_addr", s_mem_addr, 32'h1c00_0000);
    inst_req = 0; mem_addr_ok = 0;
    tick();
    mem_data_ok = 1; mem_rdata = 32'h02c0_0000;
    tick();
    chk("inst_resp_dok", s_idok, 1'b1);
    chk("inst_resp_rdata", s_irdata, 32'h02c0_0000);
    chk("inst_resp_no_ddok", s_ddok, 1'b0);
    idle(); tick();

    // ---------------- collision ----------------
    inst_req = 1; inst_addr = 32'h1c00_0010;
    data_req = 1; data_addr = 32'h0000_8000; mem_addr_ok = 1;
    tick();
    chk("coll_addr_data", s_mem_addr, 32'h0000_8000);
    chk("coll_daok", s_daok, 1'b1);
    chk("coll_no_iaok", s_iaok, 1'b0);
    data_req = 0;
    tick();
    chk("coll_addr_inst", s_mem_addr, 32'h1c00_0010);
    chk("coll_iaok", s_iaok, 1'b1);
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h1111_2222;
    tick();
    chk("coll_first_ddok", s_ddok, 1'b1);
    mem_rdata = 32'h3333_4444;
    tick();
    chk("coll_second_idok", s_idok, 1'b1);
    idle(); tick();

    // ---------------- lock ----------------
    inst_req = 1; inst_addr = 32'h1c00_0020;
    tick();
    chk("lock_c1_addr", s_mem_addr, 32'h1c00_0020);
    data_req = 1; data_addr = 32'h0000_9000;
    tick();
    chk("lock_c2_addr", s_mem_addr, 32'h1c00_0020);
    chk("lock_c2_no_daok", s_daok, 1'b0);
    tick();
    chk("lock_c3_addr", s_mem_addr, 32'h1c00_0020);
    mem_addr_ok = 1;
    tick();
    chk("lock_inst_aok", s_iaok, 1'b1);
    inst_req = 0;
    tick();
    chk("lock_data_addr", s_mem_addr, 32'h0000_9000);
    chk("lock_data_aok", s_daok, 1'b1);
    data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    tick();
    tick();
    idle(); tick();

    // ---------------- full ----------------
    mem_addr_ok = 1; inst_req = 1;
    for (int i = 0; i < MAXO; i++) begin
      inst_addr = 32'h1c00_0100 + 32'(i * 4);
      tick();
      chk("full_fill_aok", s_iaok, 1'b1);
    end
    inst_addr = 32'h1c00_0200;
    tick();
    chk("full_block_aok", s_iaok, 1'b0);
    chk("full_block_req", s_mem_req, 1'b0);
    mem_data_ok = 1;
    tick();
    chk("full_pop_same_cycle_req", s_mem_req, 1'b0);
    mem_data_ok = 0;
    tick();
    chk("full_resume_aok", s_iaok, 1'b1);
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    for (int i = 0; i < MAXO; i++) tick();
    idle(); tick();

    // ---------------- write ack ----------------
    data_req = 1; data_wr = 1; data_addr = 32'h0000_a004;
    data_wstrb = 4'b0011; data_wdata = 32'hdead_beef; mem_addr_ok = 1;
    tick();
    chk("wr_mem_wr", s_mem_wr, 1'b1);
    chk("wr_mem_wstrb", s_mem_wstrb, 4'b0011);
    chk("wr_mem_wdata", s_mem_wdata, 32'hdead_beef);
    chk("wr_daok", s_daok, 1'b1);
    data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    tick();
    chk("wr_ack_ddok", s_ddok, 1'b1);
    chk("wr_ack_no_idok", s_idok, 1'b0);
    idle(); tick();

    // ---------------- reset mid-operation ----------------
    inst_req = 1; inst_addr = 32'h1c00_0300; mem_addr_ok = 1;
    tick();
    inst_addr = 32'h1c00_0304;
    tick();
    rst = 1; inst_addr = 32'h1c00_0308;
    tick();
    chk("rstmid_mem_req", s_mem_req, 1'b0);
    chk("rstmid_iaok", s_iaok, 1'b0);
    chk("rstmid_mem_addr", s_mem_addr, 32'h0);
    rst = 0; inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    tick();
    chk("rstmid_stale1_idok", s_idok, 1'b0);
    chk("rstmid_stale1_ddok", s_ddok, 1'b0);
    tick();
    chk("rstmid_stale2_idok", s_idok, 1'b0);
    idle(); tick();

    // ---------------- randomized traffic ----------------
    for (int n = 0; n < 600; n++) begin
      if (!inst_req && $urandom_range(1) == 1) begin
        inst_req  = 1;
        inst_addr = $urandom & 32'hffff_fffc;
      end
      if (!data_req && $urandom_range(1) == 1) begin
        data_req   = 1;
        data_wr    = $urandom_range(1) == 1;
        data_addr  = $urandom;
        data_wstrb = 4'($urandom);
        data_wdata = $urandom;
      end
      mem_addr_ok = $urandom_range(3) != 0;
      mem_data_ok = $urandom_range(2) == 0;
      mem_rdata   = $urandom;
      tick();
      if (e_iaok) inst_req = 0;
      if (e_daok) data_req = 0;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_sram_bus_arbiter
`default_nettype wire

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
Shares one SRAM-like memory port (req/addr_ok/data_ok handshake) between the fetch stage's instruction channel and the MEM stage's data channel. Fixed priority with grant locking; in-order response routing via an outstanding-ID FIFO. Sits between the pipeline core and the memory bridge.

Parameters:
MAX_OUTSTANDING, 4, max accepted-but-unanswered requests (power of two, 2..16)
DATA_FIRST, 1, 1: data wins simultaneous requests; 0: inst wins

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
inst_req  in  1  instruction read request (always read, full word)
inst_addr  in  32  instruction address
inst_addr_ok  out  1  inst request accepted this cycle
inst_data_ok  out  1  inst read data valid this cycle
inst_rdata  out  32  inst read data
data_req  in  1  data request
data_wr  in  1  1 = write, 0 = read
data_addr  in  32  data address
data_wstrb  in  4  write byte strobes
data_wdata  in  32  write data
data_addr_ok  out  1  data request accepted this cycle
data_data_ok  out  1  data read return or write ack this cycle
data_rdata  out  32  data read data
mem_req  out  1  request to memory port
mem_wr  out  1  write flag to memory
mem_addr  out  32  address to memory
mem_wstrb  out  4  strobes to memory (0 for inst reads)
mem_wdata  out  32  write data to memory (0 for inst reads)
mem_addr_ok  in  1  memory accepted request
mem_data_ok  in  1  memory response valid (in request order)
mem_rdata  in  32  memory read data

Behaviour:
- Reset (async assert, sync release): lock cleared, FIFO emptied; during and after reset all outputs 0 until a request arrives; mem_req forced 0 while rst high.
- Issue allowed iff FIFO count < MAX_OUTSTANDING (full: mem_req=0, both addr_ok=0, even if a pop occurs that cycle).
- Grant: if locked, the locked requester; else per DATA_FIRST when both request, else the sole requester. Zero-latency combinational pass: mem_* driven from the granted channel the same cycle; mem_wr=0, wstrb=0, wdata=0 for inst.
- Lock: set to the granted ID when mem_req=1 and mem_addr_ok=0; cleared on the cycle mem_addr_ok=1. Requesters hold req/payload stable until addr_ok (codebase protocol); no grant switch mid-request.
- granted_addr_ok = mem_addr_ok & mem_req & grant; the other addr_ok is 0.
- Handshake (mem_req & mem_addr_ok) pushes the granted ID (0=inst, 1=data) into the FIFO.
- mem_data_ok pops the head; head ID selects inst_data_ok or data_data_ok; mem_rdata routed to both rdata outputs unchanged (consumers qualify with data_ok).
- Push and pop in the same cycle: count unchanged, both take effect.
- mem_data_ok with empty FIFO: ignored, no data_ok asserted (covers stale responses after a mid-operation reset).
- Count width clog2(MAX_OUTSTANDING)+1; pointers wrap modulo depth.
- One handshake at most per cycle; one response at most per cycle.

Decomposition:
- Shared package: requester ID constants (ID_INST=0, ID_DATA=1), reset PC 32'h1c000000 constant reused by fetch.
- One sub-module: sram_id_fifo (1-bit wide, MAX_OUTSTANDING deep, push/pop/full/empty/head), instantiated once.

Test Plan:
- Inst only: inst_req, addr 32'h1c000000, mem_addr_ok same cycle, mem_data_ok 2 cycles later with rdata 32'h02c00000 -> inst_addr_ok=1 at issue; inst_data_ok=1 with that rdata; data_data_ok stays 0.
- Collision, DATA_FIRST=1: both req same cycle -> mem_addr = data_addr, data_addr_ok=1; inst issued next cycle; responses return data then inst, in order.
- Lock: inst granted, mem_addr_ok low 3 cycles, data_req rises in cycle 2 -> mem_addr stays inst's for all 3 cycles; data issued only after inst addr_ok.
- Full: MAX_OUTSTANDING=4, 4 accepted, no responses -> 5th request sees addr_ok=0, mem_req=0; one mem_data_ok then next cycle issue resumes.
- Write ack: data_wr=1, wstrb 4'b0011, wdata 32'hdeadbeef -> mem_wr=1, mem_wstrb=4'b0011, mem_wdata=32'hdeadbeef passed through; on mem_data_ok, data_data_ok=1.
- Reset mid-op: 2 outstanding, assert rst for 1 cycle -> outputs 0 immediately; later mem_data_ok pulses produce no data_ok.
